cd_param: RTL

//  Parametrised single-cycle CPU datapath: PC, program memory, register file, ALU, Z/C flags and return stack.

---
 rtl/cd_pkg.sv | 26 ++
 rtl/ret_stack.sv | 57 +++++
 rtl/cd_param.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cd_pkg.sv
// rtl/cd_pkg.sv - shared constants for the cd_param datapath
package cd_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int PC_W_DEF      = 10;
  localparam int STK_DEPTH_DEF = 8;
  localparam logic [9:0] ISR_VEC_DEF = 10'h3F0;

  localparam logic [2:0] ALU_A    = 3'b000;
  localparam logic [2:0] ALU_NOTA = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NEGA = 3'b110;
  localparam logic [2:0] ALU_NEGB = 3'b111;

  localparam int OPC_LSB = 16;
  localparam int RA1_LSB = 8;
  localparam int RA2_LSB = 4;
  localparam int WA3_LSB = 0;
  localparam int IMM_LSB = 4;
  localparam int IMM_W   = 8;
  localparam int REG_AW  = 4;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address stack with sticky overflow/underflow
module ret_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [0:DEPTH-1];
  logic [AW:0]   cnt;
  logic [AW-1:0] sp;

  // sp wraps to DEPTH-1 when full because DEPTH is a power of two
  assign sp    = cnt[AW-1:0] - 1'b1;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign top   = mem[sp];

  // push/pop bookkeeping; push&pop together overwrites the top (tail call)
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (push && pop) begin
      if (empty) begin
        mem[0] <= din;
        cnt    <= (AW+1)'(1);
        unf    <= 1'b1;
      end else begin
        mem[sp] <= din;
      end
    end else if (push) begin
      if (full) begin
        ovf <= 1'b1;
      end else begin
        mem[cnt[AW-1:0]] <= din;
        cnt <= cnt + 1'b1;
      end
    end else if (pop) begin
      if (empty) unf <= 1'b1;
      else       cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/cd_param.sv
// rtl/cd_param.sv - single-cycle datapath with return stack and one-level interrupt
module cd_param
  import cd_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PC_W      = PC_W_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF,
  parameter logic [PC_W-1:0] ISR_VEC = PC_W'(ISR_VEC_DEF),
  parameter logic [31:0] PROG [0:(1<<PC_W)-1] = '{default: 32'h0}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_inc,
  input  logic        s_inm,
  input  logic        we3,
  input  logic        wez,
  input  logic        push,
  input  logic        pop,
  input  logic        reti,
  input  logic        intr,
  input  logic [2:0]  op_alu,
  output logic        z,
  output logic        carry,
  output logic [15:0] opcode,
  output logic        in_isr,
  output logic        stk_ovf,
  output logic        stk_unf
);

  logic [PC_W-1:0]   pc, pc_inc, pc_seq, pc_nxt;
  logic [31:0]       inst;
  logic [DATA_W-1:0] regs [0:(1<<REG_AW)-1];
  logic [DATA_W-1:0] rd1, rd2, op_a, alu_y;
  logic [DATA_W:0]   alu_ext;
  logic              alu_z, alu_c, z_nxt, c_nxt;
  logic [1:0]        shadow;
  logic              pending, pend_now, accept, reti_isr;
  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_W-1:0]   stk_din, stk_top;
  logic              unused_inst;

  assign inst        = PROG[pc];
  assign opcode      = inst[OPC_LSB +: 16];
  assign unused_inst = ^inst[15:12];

  assign rd1  = regs[inst[RA1_LSB +: REG_AW]];
  assign rd2  = regs[inst[RA2_LSB +: REG_AW]];
  assign op_a = s_inm ? DATA_W'(inst[IMM_LSB +: IMM_W]) : rd1;

  // ALU; carry is the add carry-out or the subtract borrow
  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_ext = '0;
    case (op_alu)
      ALU_A:    alu_y = op_a;
      ALU_NOTA: alu_y = ~op_a;
      ALU_ADD: begin
        alu_ext = {1'b0, op_a} + {1'b0, rd2};
        alu_y   = alu_ext[DATA_W-1:0];
        alu_c   = alu_ext[DATA_W];
      end
      ALU_SUB: begin
        alu_ext = {1'b0, op_a} - {1'b0, rd2};
        alu_y   = alu_ext[DATA_W-1:0];
        alu_c   = alu_ext[DATA_W];
      end
      ALU_AND:  alu_y = op_a & rd2;
      ALU_OR:   alu_y = op_a | rd2;
      ALU_NEGA: alu_y = '0 - op_a;
      ALU_NEGB: alu_y = '0 - rd2;
    endcase
  end

  assign alu_z = (alu_y == '0);

  // register file write, no reset on contents
  always_ff @(posedge clk) begin
    if (we3) regs[inst[WA3_LSB +: REG_AW]] <= alu_y;
  end

  assign reti_isr = reti & in_isr;
  assign pend_now = pending | intr;
  assign accept   = pend_now & ~in_isr & ~push & ~pop & ~reti & ~stk_full;
  assign pc_inc   = pc + 1'b1;
  assign pc_seq   = s_inc ? pc_inc : inst[PC_W-1:0];
  assign stk_pop  = pop | reti;
  assign stk_push = push | accept;
  assign stk_din  = accept ? pc_seq : pc_inc;

  // next PC and next flags; reti restores flags from the shadow and ignores wez
  always_comb begin
    pc_nxt = pc_seq;
    if (stk_pop)     pc_nxt = stk_empty ? pc_inc : stk_top;
    else if (accept) pc_nxt = ISR_VEC;
    z_nxt = z;
    c_nxt = carry;
    if (reti_isr) {z_nxt, c_nxt} = shadow;
    else if (wez) {z_nxt, c_nxt} = {alu_z, alu_c};
  end

  // architectural state: PC, flags, interrupt bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      z       <= 1'b0;
      carry   <= 1'b0;
      in_isr  <= 1'b0;
      pending <= 1'b0;
      shadow  <= 2'b00;
    end else begin
      pc      <= pc_nxt;
      z       <= z_nxt;
      carry   <= c_nxt;
      pending <= pend_now & ~accept;
      if (accept) begin
        in_isr <= 1'b1;
        shadow <= {z_nxt, c_nxt};
      end else if (reti_isr) begin
        in_isr <= 1'b0;
      end
    end
  end

  ret_stack #(.W(PC_W), .DEPTH(STK_DEPTH)) u_stk (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (stk_din),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .ovf   (stk_ovf),
    .unf   (stk_unf)
  );

endmodule
